// File: rtl/wb_rst_seq.sv
// Reset sequencer: synchronises master reset release and releases NUM_CH channel resets in a staggered schedule, with software re-reset and run watchdog.
// Latency: rst assert -> outputs immediately; release -> channel i drops SYNC_STAGES+RST_DELAY+i*STAGGER edges later.
// Backpressure: none; sw_rst_req is level-sensitive and holds the sequence at its start while high.
module wb_rst_seq #(
    parameter int NUM_CH         = 2,
    parameter int SYNC_STAGES    = 2,
    parameter int RST_DELAY      = 5,
    parameter int STAGGER        = 2,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int CNT_W          = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sw_rst_req,
    output logic [NUM_CH-1:0] ch_rst_o,
    output logic              all_ready,
    output logic              timeout,
    output logic [CNT_W-1:0]  cycle_cnt
);

    localparam longint LAST_THR = longint'(RST_DELAY) + longint'(NUM_CH - 1) * longint'(STAGGER);
    localparam longint CNT_MAX  = (longint'(1) << CNT_W) - 1;

    localparam logic [CNT_W-1:0] LAST_THR_C = CNT_W'(LAST_THR);
    localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(TIMEOUT_CYCLES);

    // Parameter sanity checks, evaluated at elaboration
    if (NUM_CH < 1) begin : g_bad_num_ch
        $error("wb_rst_seq: NUM_CH must be >= 1");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("wb_rst_seq: SYNC_STAGES must be >= 2");
    end
    if (RST_DELAY < 1) begin : g_bad_delay
        $error("wb_rst_seq: RST_DELAY must be >= 1");
    end
    if (STAGGER < 0 || TIMEOUT_CYCLES < 0) begin : g_bad_neg
        $error("wb_rst_seq: STAGGER and TIMEOUT_CYCLES must be non-negative");
    end
    if (LAST_THR > CNT_MAX) begin : g_bad_sched
        $error("wb_rst_seq: release schedule does not fit in CNT_W bits");
    end
    if (longint'(TIMEOUT_CYCLES) > CNT_MAX) begin : g_bad_timeout
        $error("wb_rst_seq: TIMEOUT_CYCLES does not fit in CNT_W bits");
    end

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        SEQ  = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t state_q, state_d;

    // The FSM state register acts as the final synchroniser stage: it is
    // forced to SYNC by rst and leaves SYNC one edge after the last of these
    // flops clears, giving SYNC_STAGES edges from rst release to SEQ.
    logic [SYNC_STAGES-2:0] sync_q;
    logic                   sync_rel;

    logic [CNT_W-1:0]  seq_cnt_q, seq_cnt_d, seq_inc;
    logic              seq_hold_q, seq_hold_d;
    logic [CNT_W-1:0]  cycle_inc, cycle_cnt_d;
    logic [NUM_CH-1:0] ch_rst_d;
    logic              all_ready_d, timeout_d;

    function automatic logic [CNT_W-1:0] thr(input int ch);
        return CNT_W'(RST_DELAY + ch * STAGGER);
    endfunction

    assign sync_rel = ~sync_q[SYNC_STAGES-2];

    // A software request leaves a one-edge hold so the schedule counts from
    // the first edge the request is seen low, matching the power-on case.
    assign seq_inc   = seq_hold_q ? '0 : seq_cnt_q + CNT_W'(1);
    assign cycle_inc = (cycle_cnt == '1) ? cycle_cnt : cycle_cnt + CNT_W'(1);

    // Reset-release synchroniser: preset by rst, shifts in zeros
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= sync_q << 1;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a software request always wins over entering RUN
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SYNC: if (sync_rel) state_d = SEQ;
            SEQ: begin
                if (sw_rst_req) begin
                    state_d = SEQ;
                end else if (seq_inc == LAST_THR_C) begin
                    state_d = RUN;
                end
            end
            RUN:     if (sw_rst_req) state_d = SEQ;
            default: state_d = SYNC;
        endcase
    end

    // Output/datapath next values; every output is registered below
    always_comb begin
        seq_cnt_d   = seq_cnt_q;
        seq_hold_d  = 1'b0;
        ch_rst_d    = ch_rst_o;
        cycle_cnt_d = cycle_cnt;
        timeout_d   = timeout;
        all_ready_d = (state_d == RUN);
        unique case (state_q)
            SYNC: begin
                seq_cnt_d   = '0;
                ch_rst_d    = '1;
                cycle_cnt_d = '0;
            end
            SEQ: begin
                if (sw_rst_req) begin
                    seq_cnt_d  = '0;
                    seq_hold_d = 1'b1;
                    ch_rst_d   = '1;
                end else begin
                    seq_cnt_d = seq_inc;
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (seq_inc == thr(i)) ch_rst_d[i] = 1'b0;
                    end
                end
            end
            RUN: begin
                // The watchdog still fires on the edge a request arrives
                if (TIMEOUT_CYCLES != 0 && cycle_inc == TIMEOUT_C) timeout_d = 1'b1;
                if (sw_rst_req) begin
                    seq_cnt_d   = '0;
                    seq_hold_d  = 1'b1;
                    ch_rst_d    = '1;
                    cycle_cnt_d = '0;
                end else begin
                    cycle_cnt_d = cycle_inc;
                end
            end
            default: begin
                seq_cnt_d   = '0;
                ch_rst_d    = '1;
                cycle_cnt_d = '0;
            end
        endcase
    end

    // Output and counter registers, all cleared/preset asynchronously by rst
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seq_cnt_q  <= '0;
            seq_hold_q <= 1'b0;
            ch_rst_o   <= '1;
            all_ready  <= 1'b0;
            timeout    <= 1'b0;
            cycle_cnt  <= '0;
        end else begin
            seq_cnt_q  <= seq_cnt_d;
            seq_hold_q <= seq_hold_d;
            ch_rst_o   <= ch_rst_d;
            all_ready  <= all_ready_d;
            timeout    <= timeout_d;
            cycle_cnt  <= cycle_cnt_d;
        end
    end

endmodule

// File: tb/tb_wb_rst_seq.sv
// Bench for wb_rst_seq: default build with a 20-cycle watchdog plus a 4-channel,
// zero-stagger build with the watchdog disabled, both sharing clk/rst/sw_rst_req.
// Table rows advance a number of edges with a given request level, then compare.
module tb_wb_rst_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        sw_rst_req;

    logic [1:0]  ch;
    logic        rdy;
    logic        to;
    logic [15:0] cnt;

    logic [3:0]  ch4;
    logic        rdy4;
    logic        to4;
    logic [15:0] cnt4;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    wb_rst_seq #(
        .NUM_CH(2), .SYNC_STAGES(2), .RST_DELAY(5), .STAGGER(2),
        .TIMEOUT_CYCLES(20), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .sw_rst_req(sw_rst_req),
        .ch_rst_o(ch), .all_ready(rdy), .timeout(to), .cycle_cnt(cnt)
    );

    wb_rst_seq #(
        .NUM_CH(4), .SYNC_STAGES(2), .RST_DELAY(1), .STAGGER(0),
        .TIMEOUT_CYCLES(0), .CNT_W(16)
    ) dut4 (
        .clk(clk), .rst(rst), .sw_rst_req(sw_rst_req),
        .ch_rst_o(ch4), .all_ready(rdy4), .timeout(to4), .cycle_cnt(cnt4)
    );

    typedef struct {
        int          adv;
        logic        sw;
        logic [1:0]  ch;
        logic        rdy;
        logic [15:0] cnt;
        logic        to;
        logic [3:0]  ch4;
        logic        rdy4;
    } vec_t;

    vec_t vecs[27];

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] e_ch, input logic e_rdy,
                           input logic [15:0] e_cnt, input logic e_to,
                           input logic [3:0] e_ch4, input logic e_rdy4);
        cmp({tag, ".ch_rst_o"},   32'(ch),   32'(e_ch));
        cmp({tag, ".all_ready"},  32'(rdy),  32'(e_rdy));
        cmp({tag, ".cycle_cnt"},  32'(cnt),  32'(e_cnt));
        cmp({tag, ".timeout"},    32'(to),   32'(e_to));
        cmp({tag, ".ch_rst_o4"},  32'(ch4),  32'(e_ch4));
        cmp({tag, ".all_ready4"}, 32'(rdy4), 32'(e_rdy4));
    endtask

    task automatic step(input int n, input logic s);
        sw_rst_req = s;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // Edge numbers in comments count rising edges after power-on rst release
        vecs[0]  = '{2,    1'b0, 2'b11, 1'b0, 16'd0,  1'b0, 4'hf, 1'b0}; // e2
        vecs[1]  = '{1,    1'b0, 2'b11, 1'b0, 16'd0,  1'b0, 4'h0, 1'b1}; // e3: 4-ch all drop
        vecs[2]  = '{3,    1'b0, 2'b11, 1'b0, 16'd0,  1'b0, 4'h0, 1'b1}; // e6
        vecs[3]  = '{1,    1'b0, 2'b10, 1'b0, 16'd0,  1'b0, 4'h0, 1'b1}; // e7: ch0
        vecs[4]  = '{1,    1'b0, 2'b10, 1'b0, 16'd0,  1'b0, 4'h0, 1'b1}; // e8
        vecs[5]  = '{1,    1'b0, 2'b00, 1'b1, 16'd0,  1'b0, 4'h0, 1'b1}; // e9: ch1 + ready
        vecs[6]  = '{1,    1'b0, 2'b00, 1'b1, 16'd1,  1'b0, 4'h0, 1'b1}; // e10
        vecs[7]  = '{18,   1'b0, 2'b00, 1'b1, 16'd19, 1'b0, 4'h0, 1'b1}; // e28
        vecs[8]  = '{1,    1'b0, 2'b00, 1'b1, 16'd20, 1'b1, 4'h0, 1'b1}; // e29: watchdog
        vecs[9]  = '{3,    1'b0, 2'b00, 1'b1, 16'd23, 1'b1, 4'h0, 1'b1}; // e32
        vecs[10] = '{1,    1'b1, 2'b11, 1'b0, 16'd0,  1'b1, 4'hf, 1'b0}; // e33: request
        vecs[11] = '{2,    1'b1, 2'b11, 1'b0, 16'd0,  1'b1, 4'hf, 1'b0}; // e35: held
        vecs[12] = '{1,    1'b0, 2'b11, 1'b0, 16'd0,  1'b1, 4'hf, 1'b0}; // e36: first low
        vecs[13] = '{4,    1'b0, 2'b11, 1'b0, 16'd0,  1'b1, 4'h0, 1'b1}; // e40
        vecs[14] = '{1,    1'b0, 2'b10, 1'b0, 16'd0,  1'b1, 4'h0, 1'b1}; // e41: ch0
        vecs[15] = '{2,    1'b0, 2'b00, 1'b1, 16'd0,  1'b1, 4'h0, 1'b1}; // e43: ch1
        vecs[16] = '{3,    1'b0, 2'b00, 1'b1, 16'd3,  1'b1, 4'h0, 1'b1}; // e46
        vecs[17] = '{1,    1'b1, 2'b11, 1'b0, 16'd0,  1'b1, 4'hf, 1'b0}; // e47: pulse
        vecs[18] = '{1,    1'b0, 2'b11, 1'b0, 16'd0,  1'b1, 4'hf, 1'b0}; // e48
        vecs[19] = '{5,    1'b0, 2'b10, 1'b0, 16'd0,  1'b1, 4'h0, 1'b1}; // e53: ch0
        vecs[20] = '{1,    1'b0, 2'b10, 1'b0, 16'd0,  1'b1, 4'h0, 1'b1}; // e54
        vecs[21] = '{1,    1'b1, 2'b11, 1'b0, 16'd0,  1'b1, 4'hf, 1'b0}; // e55: collides with ch1
        vecs[22] = '{5,    1'b0, 2'b11, 1'b0, 16'd0,  1'b1, 4'h0, 1'b1}; // e60
        vecs[23] = '{1,    1'b0, 2'b10, 1'b0, 16'd0,  1'b1, 4'h0, 1'b1}; // e61: ch0
        vecs[24] = '{2,    1'b0, 2'b00, 1'b1, 16'd0,  1'b1, 4'h0, 1'b1}; // e63: ch1
        vecs[25] = '{1,    1'b1, 2'b11, 1'b0, 16'd0,  1'b1, 4'hf, 1'b0}; // e64: pulse
        vecs[26] = '{6,    1'b0, 2'b10, 1'b0, 16'd0,  1'b1, 4'h0, 1'b1}; // e70: mid-SEQ

        rst        = 1'b1;
        sw_rst_req = 1'b0;
        #2;
        chk_all("reset", 2'b11, 1'b0, 16'd0, 1'b0, 4'hf, 1'b0);

        // Release between edges, then walk the table
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 27; i++) begin
            step(vecs[i].adv, vecs[i].sw);
            chk_all($sformatf("row%0d", i), vecs[i].ch, vecs[i].rdy, vecs[i].cnt,
                    vecs[i].to, vecs[i].ch4, vecs[i].rdy4);
        end

        // rst mid-SEQ: immediate reassert, held 1.5 cycles, released between edges
        rst = 1'b1;
        #1;
        chk_all("rst_async", 2'b11, 1'b0, 16'd0, 1'b0, 4'hf, 1'b0);
        #14;
        rst = 1'b0;
        step(6, 1'b0);
        chk_all("rerun_e6", 2'b11, 1'b0, 16'd0, 1'b0, 4'h0, 1'b1);
        step(1, 1'b0);
        chk_all("rerun_e7", 2'b10, 1'b0, 16'd0, 1'b0, 4'h0, 1'b1);
        step(2, 1'b0);
        chk_all("rerun_e9", 2'b00, 1'b1, 16'd0, 1'b0, 4'h0, 1'b1);
        step(20, 1'b0);
        chk_all("rerun_e29", 2'b00, 1'b1, 16'd20, 1'b1, 4'h0, 1'b1);

        // Long run: disabled watchdog must stay quiet, counters keep counting
        step(9980, 1'b0);
        cmp("long.cycle_cnt",  32'(cnt),  32'd10000);
        cmp("long.timeout",    32'(to),   32'd1);
        cmp("long.timeout4",   32'(to4),  32'd0);
        cmp("long.cycle_cnt4", 32'(cnt4), 32'd10006);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
